// File: rtl/piezo_alert_sched.sv
// piezo_alert_sched: prioritised piezo alert sequencer (danger / limit / gear).
// Optional feature macro: PIEZO_COOLDOWN_EN. When it is defined, a silent COOL
// phase separates alerts. When it is undefined, sequences return straight to IDLE.
//
// state   | meaning
// IDLE    | nothing sounding, picks next request (danger > limit > gear)
// DNG_ON  | danger beep, high tone, BEEP_MS
// DNG_OFF | danger gap, silent, BEEP_MS
// LIM_ON1 | first limit beep, low tone, BEEP_MS
// LIM_GAP | limit gap, silent, BEEP_MS
// LIM_ON2 | second limit beep, low tone, BEEP_MS
// GEAR_ON | gear chirp, high tone, CHIRP_MS
// COOL    | silent spacing between alerts, COOL_MS (PIEZO_COOLDOWN_EN only)
module piezo_alert_sched #(
  parameter int TONE_HI_DIV = 50000,
  parameter int TONE_LO_DIV = 100000,
  parameter int BEEP_MS     = 100,
  parameter int CHIRP_MS    = 50,
  parameter int COOL_MS     = 20
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tick_1khz,
  input  logic       req_danger,
  input  logic       req_limit,
  input  logic       req_gear,
  output logic       piezo,
  output logic [2:0] grant,
  output logic       busy
);

  localparam int MS_MAX0 = (BEEP_MS > CHIRP_MS) ? BEEP_MS : CHIRP_MS;
  localparam int MS_MAX  = (MS_MAX0 > COOL_MS) ? MS_MAX0 : COOL_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);
  localparam int DIV_MAX = (TONE_HI_DIV > TONE_LO_DIV) ? TONE_HI_DIV : TONE_LO_DIV;
  localparam int TN_W    = $clog2(DIV_MAX + 1);

  localparam logic [MS_W-1:0] BEEP_TC  = MS_W'(BEEP_MS - 1);
  localparam logic [MS_W-1:0] CHIRP_TC = MS_W'(CHIRP_MS - 1);
  localparam logic [TN_W-1:0] HI_TC    = TN_W'(TONE_HI_DIV - 1);
  localparam logic [TN_W-1:0] LO_TC    = TN_W'(TONE_LO_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, DNG_ON, DNG_OFF, LIM_ON1, LIM_GAP, LIM_ON2, GEAR_ON
`ifdef PIEZO_COOLDOWN_EN
    , COOL
`endif
  } state_t;

`ifdef PIEZO_COOLDOWN_EN
  localparam state_t SEQ_END = COOL;
  localparam logic [MS_W-1:0] COOL_TC = MS_W'(COOL_MS - 1);
`else
  localparam state_t SEQ_END = IDLE;
`endif

  state_t            state, state_nxt;
  logic [MS_W-1:0]   ms_cnt;
  logic [TN_W-1:0]   tone_cnt, tone_tc;
  logic              tone_en;
  logic              lim_pend, gear_pend, lim_clr, gear_clr;
  logic [2:0]        grant_nxt;
  logic              beep_done, chirp_done;

  assign beep_done  = tick_1khz && (ms_cnt == BEEP_TC);
  assign chirp_done = tick_1khz && (ms_cnt == CHIRP_TC);
  assign busy       = (state != IDLE);

  // Next-state selection and pending-flag consumption.
  always_comb begin
    state_nxt = state;
    lim_clr   = 1'b0;
    gear_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (req_danger) state_nxt = DNG_ON;
        else if (lim_pend) begin
          state_nxt = LIM_ON1;
          lim_clr   = 1'b1;
        end else if (gear_pend) begin
          state_nxt = GEAR_ON;
          gear_clr  = 1'b1;
        end
      end
      DNG_ON:  if (!req_danger) state_nxt = SEQ_END; else if (beep_done) state_nxt = DNG_OFF;
      DNG_OFF: if (!req_danger) state_nxt = SEQ_END; else if (beep_done) state_nxt = DNG_ON;
      LIM_ON1: if (req_danger) state_nxt = DNG_ON; else if (beep_done) state_nxt = LIM_GAP;
      LIM_GAP: if (req_danger) state_nxt = DNG_ON; else if (beep_done) state_nxt = LIM_ON2;
      LIM_ON2: if (req_danger) state_nxt = DNG_ON; else if (beep_done) state_nxt = SEQ_END;
      GEAR_ON: if (req_danger) state_nxt = DNG_ON; else if (chirp_done) state_nxt = SEQ_END;
`ifdef PIEZO_COOLDOWN_EN
      COOL: if (tick_1khz && (ms_cnt == COOL_TC)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Tone selection for the current state; silent states leave tone_en low.
  always_comb begin
    tone_en = 1'b0;
    tone_tc = '0;
    case (state)
      DNG_ON, GEAR_ON: begin
        tone_en = 1'b1;
        tone_tc = HI_TC;
      end
      LIM_ON1, LIM_ON2: begin
        tone_en = 1'b1;
        tone_tc = LO_TC;
      end
      default: tone_en = 1'b0;
    endcase
  end

  // Owner of the sequence being entered, registered so grant is glitch-free.
  always_comb begin
    grant_nxt = 3'b000;
    case (state_nxt)
      DNG_ON, DNG_OFF:           grant_nxt = 3'b100;
      LIM_ON1, LIM_GAP, LIM_ON2: grant_nxt = 3'b010;
      GEAR_ON:                   grant_nxt = 3'b001;
      default:                   grant_nxt = 3'b000;
    endcase
  end

  // State, pending flags, ms timer and tone divider registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lim_pend  <= 1'b0;
      gear_pend <= 1'b0;
      ms_cnt    <= '0;
      tone_cnt  <= '0;
      piezo     <= 1'b0;
      grant     <= 3'b000;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      // A pulse landing on the consuming edge is a fresh request and survives.
      lim_pend  <= req_limit | (lim_pend & ~lim_clr);
      gear_pend <= req_gear | (gear_pend & ~gear_clr);
      // IDLE holds the timer at zero so it can never wrap while waiting.
      if ((state_nxt != state) || (state_nxt == IDLE)) ms_cnt <= '0;
      else if (tick_1khz) ms_cnt <= ms_cnt + 1'b1;
      if ((state_nxt != state) || !tone_en) begin
        tone_cnt <= '0;
        piezo    <= 1'b0;
      end else if (tone_cnt == tone_tc) begin
        tone_cnt <= '0;
        piezo    <= ~piezo;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Bench for piezo_alert_sched: directed scenarios followed by random requests,
// every cycle compared against a segment-list model of the alert sequences.
module tb_piezo_alert_sched;
  localparam int HI = 3, LO = 5, BEEP = 4, CHIRP = 3, COOLP = 2, TICK_P = 7;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1khz = 1'b0, req_danger = 1'b0, req_limit = 1'b0, req_gear = 1'b0;
  logic       piezo;
  logic [2:0] grant;
  logic       busy;

  int vectors = 0, miscompares = 0, cyc = 0;

  piezo_alert_sched #(
    .TONE_HI_DIV(HI), .TONE_LO_DIV(LO), .BEEP_MS(BEEP), .CHIRP_MS(CHIRP), .COOL_MS(COOLP)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .tick_1khz(tick_1khz),
    .req_danger(req_danger), .req_limit(req_limit), .req_gear(req_gear),
    .piezo(piezo), .grant(grant), .busy(busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Model: an alert is a list of segments (tone divider or 0 for silence,
  // length in ticks, owner bit pattern, cool flag).
  typedef struct { int div; int len; int owner; bit cool; } seg_t;
  seg_t cur;
  seg_t q[$];
  bit   m_act, m_lim, m_gear;
  int   m_ticks, m_cycles;

  function automatic seg_t mk(input int div, input int len, input int owner, input bit cool);
    seg_t s;
    s.div = div; s.len = len; s.owner = owner; s.cool = cool;
    return s;
  endfunction

  task automatic m_start(input seg_t s);
    cur = s; m_ticks = 0; m_cycles = 0; m_act = 1'b1;
  endtask

  task automatic m_reset();
    q.delete(); m_act = 1'b0; m_lim = 1'b0; m_gear = 1'b0;
    m_ticks = 0; m_cycles = 0; cur = mk(0, 1, 0, 1'b0);
  endtask

  task automatic m_tail();
`ifdef PIEZO_COOLDOWN_EN
    q.push_back(mk(0, COOLP, 0, 1'b1));
`endif
  endtask

  task automatic m_next();
    if (q.size() > 0) m_start(q.pop_front());
    else begin m_act = 1'b0; cur = mk(0, 1, 0, 1'b0); end
  endtask

  task automatic m_step(input bit tick, input bit dng, input bit lim, input bit gear);
    bit lclr, gclr, ended;
    lclr = 1'b0; gclr = 1'b0;
    if (!m_act) begin
      if (dng) m_start(mk(HI, BEEP, 4, 1'b0));
      else if (m_lim) begin
        lclr = 1'b1;
        q.delete();
        q.push_back(mk(0, BEEP, 2, 1'b0));
        q.push_back(mk(LO, BEEP, 2, 1'b0));
        m_tail();
        m_start(mk(LO, BEEP, 2, 1'b0));
      end else if (m_gear) begin
        gclr = 1'b1;
        q.delete();
        m_tail();
        m_start(mk(HI, CHIRP, 1, 1'b0));
      end
    end else begin
      ended = tick && (m_ticks + 1 == cur.len);
      if (cur.owner == 4 && !dng) begin
        q.delete(); m_tail(); m_next();
      end else if ((cur.owner == 1 || cur.owner == 2) && dng) begin
        q.delete(); m_start(mk(HI, BEEP, 4, 1'b0));
      end else if (ended) begin
        if (cur.owner == 4) m_start(mk((cur.div != 0) ? 0 : HI, BEEP, 4, 1'b0));
        else m_next();
      end else begin
        m_ticks += int'(tick); m_cycles++;
      end
    end
    m_lim  = (m_lim && !lclr) || lim;
    m_gear = (m_gear && !gclr) || gear;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_pz;
    exp_pz = (m_act && cur.div != 0) ? logic'((m_cycles / cur.div) % 2) : 1'b0;
    chk("piezo", 32'(piezo), 32'(exp_pz));
    chk("grant", 32'(grant), m_act ? 32'(cur.owner) : 32'd0);
    chk("busy",  32'(busy),  32'(m_act));
  endtask

  task automatic cycle(input bit dng, input bit lim, input bit gear);
    req_danger = dng; req_limit = lim; req_gear = gear;
    tick_1khz = ((cyc % TICK_P) == TICK_P - 1);
    @(posedge clk_100mhz);
    cyc++;
    if (rst_n) m_step(tick_1khz, dng, lim, gear); else m_reset();
    #1;
    check_all();
    req_limit = 1'b0; req_gear = 1'b0;
  endtask

  task automatic idle_run(input int n, input bit dng);
    repeat (n) cycle(dng, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_piezo", 32'(piezo), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    idle_run(hold, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit dng;
    m_reset();
    // Held in reset from time zero.
    idle_run(3, 1'b0);
    rst_n = 1'b1;
    idle_run(5, 1'b0);
    // Single gear chirp.
    cycle(1'b0, 1'b0, 1'b1);
    idle_run(50, 1'b0);
    // Single limit sequence.
    cycle(1'b0, 1'b1, 1'b0);
    idle_run(110, 1'b0);
    // Limit and gear in the same cycle: limit first, then gear.
    cycle(1'b0, 1'b1, 1'b1);
    idle_run(160, 1'b0);
    // Danger raised partway into the first limit beep; limit must not replay.
    cycle(1'b0, 1'b1, 1'b0);
    idle_run(17, 1'b0);
    idle_run(40, 1'b1);
    idle_run(90, 1'b0);
    // Danger held for 3.5 beeps, then released.
    idle_run(TICK_P * BEEP * 7 / 2, 1'b1);
    idle_run(30, 1'b0);
    // Reset mid danger beep with a gear request pending; silence afterwards.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    idle_run(HI + 1, 1'b1);
    chk("pre_rst_piezo", 32'(piezo), 32'd1);
    async_reset(3);
    idle_run(60, 1'b0);
    // Random requests.
    dng = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) dng = ~dng;
      if ($urandom_range(0, 1999) == 0) async_reset(2);
      else cycle(dng, $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
    end
    idle_run(100, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piezo_alert_sched.md
PIEZO_ALERT_SCHED -- requirements
Module: piezo_alert_sched

Interface
REQ-001 SHALL have parameter TONE_HI_DIV, default 50000, clk_100mhz cycles per half-period of the high tone (1 kHz).
REQ-002 SHALL have parameter TONE_LO_DIV, default 100000, clk_100mhz cycles per half-period of the low tone (500 Hz).
REQ-003 SHALL have parameter BEEP_MS, default 100, length in ms of danger/limit beeps and gaps.
REQ-004 SHALL have parameter CHIRP_MS, default 50, length in ms of the gear chirp.
REQ-005 SHALL have parameter COOL_MS, default 20, length in ms of the silent gap between alerts.
REQ-006 clk_100mhz  in  1  sole clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 tick_1khz  in  1  one-cycle strobe, once per ms, synchronous to clk_100mhz.
REQ-009 req_danger  in  1  level request: over-rev danger zone.
REQ-010 req_limit  in  1  one-cycle pulse request: speed limit crossed.
REQ-011 req_gear  in  1  one-cycle pulse request: gear changed.
REQ-012 piezo  out  1  square-wave drive to the piezo.
REQ-013 grant  out  3  one-hot owner {danger, limit, gear}; 000 when no alert is sounding or in a gap.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, DNG_ON, DNG_OFF, LIM_ON1, LIM_GAP, LIM_ON2, GEAR_ON, COOL.
REQ-016 Ms counter SHALL advance only on tick_1khz; it clears on every state entry; a phase of N ms ends on the Nth tick after entry.
REQ-017 Pulse requests SHALL set pending flags lim_pend/gear_pend in any state; repeated pulses while pending merge into one.
REQ-018 Pending flag SHALL clear in the cycle its sequence is entered from IDLE.
REQ-019 Priority from IDLE SHALL be danger > limit > gear, evaluated every cycle.
REQ-020 Danger: DNG_ON (high tone, BEEP_MS) <-> DNG_OFF (silent, BEEP_MS), repeating while req_danger is high.
REQ-021 req_danger low in DNG_ON or DNG_OFF SHALL go to COOL on the next clock.
REQ-022 Limit: LIM_ON1 (low tone, BEEP_MS) -> LIM_GAP (silent, BEEP_MS) -> LIM_ON2 (low tone, BEEP_MS) -> COOL.
REQ-023 Gear: GEAR_ON (high tone, CHIRP_MS) -> COOL.
REQ-024 req_danger high in any limit or gear state SHALL abort that sequence, without re-arming its pending flag, and enter DNG_ON next clock.
REQ-025 Limit and gear sequences SHALL NOT preempt each other; a new request waits as pending.
REQ-026 COOL SHALL be silent for COOL_MS and then return to IDLE; req_danger in COOL SHALL be deferred until IDLE.
REQ-027 Tone generator: a half-period counter SHALL toggle piezo each DIV cycles while the state is a tone state; the counter and piezo SHALL be forced to 0 on every state change and in silent states.
REQ-028 First piezo rising edge SHALL occur DIV cycles after tone state entry.
REQ-029 grant SHALL be registered and reflect the current sequence owner, including its gap states; COOL and IDLE give 000.
REQ-030 Counters SHALL be sized with $clog2 of their maximum value; no overflow wrap SHALL occur for legal parameters.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, piezo=0, grant=000, busy=0, clear both pending flags, the ms counter and the tone counter.
REQ-032 Reset asserted mid-sequence SHALL discard the sequence and its pending requests; after release, operation SHALL start from IDLE.

Configuration
REQ-033 With PIEZO_COOLDOWN_EN defined, COOL SHALL behave as in REQ-026.
REQ-034 Without PIEZO_COOLDOWN_EN, every transition to COOL SHALL instead go directly to IDLE, and the COOL state and COOL_MS logic SHALL be absent.

Verification
REQ-035 Single req_gear pulse from IDLE -> grant=001 for 50 ticks, piezo toggles every 50000 cycles, then 20 silent ticks, busy=0.
REQ-036 Single req_limit pulse -> 100 ms low tone (toggles every 100000 cycles), then 100 ms silent, then 100 ms low tone, grant=010 throughout, then COOL.
REQ-037 req_limit and req_gear pulsed in the same cycle -> limit sequence, COOL, then gear chirp; no second limit.
REQ-038 req_danger raised 30 ms into LIM_ON1 -> DNG_ON next clock, grant=100, limit not replayed after danger drops.
REQ-039 req_danger held for 350 ms -> on/off/on/off pattern at 100 ms each, then COOL on deassert, piezo=0.
REQ-040 rst_n low during DNG_ON with gear_pend set -> piezo=0, grant=000 immediately; after release, no alert sounds.
